// File: rtl/counter_timer_ctrl.sv
// Register-mapped timer controller driving an external 32-bit up/down counter.
// Owns hold/reload/start sequencing through the counter's Load/PData/s inputs.
module counter_timer_ctrl #(
    parameter int W    = 32,
    parameter int WC_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [1:0]   addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    input  logic [W-1:0] cnt_in,
    input  logic         rc_in,
    output logic         load_o,
    output logic         s_o,
    output logic [W-1:0] pdata_o,
    output logic         irq_o
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state;
    logic [3:0]      ctrl;
    logic [W-1:0]    reload;
    logic            flag;
    logic [WC_W-1:0] wrap_cnt;
    logic            rc_valid;

    logic ctrl_wr, reload_wr, status_wr, wrap;

    assign ctrl_wr   = we && (addr == 2'd0);
    assign reload_wr = we && (addr == 2'd1);
    assign status_wr = we && (addr == 2'd2);

    // Rc is stale after any Load cycle, so only trust it after a counting cycle.
    assign wrap = (state == RUN) && rc_valid && rc_in;

    assign s_o   = ctrl[1];
    assign irq_o = flag & ctrl[3];

    // A one-shot wrap also loads, with cnt_in, so the counter freezes on the
    // post-wrap value instead of counting one step past it.
    always_comb begin
        load_o  = 1'b1;
        pdata_o = reload;
        case (state)
            IDLE:        pdata_o = reload;
            RUN: begin
                load_o  = wrap;
                pdata_o = ctrl[2] ? reload : cnt_in;
            end
            PAUSE, DONE: pdata_o = cnt_in;
            default:     pdata_o = reload;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[3:0] = ctrl;
            2'd1: rdata      = reload;
            2'd2: begin
                rdata[0]          = flag;
                rdata[8 +: WC_W]  = wrap_cnt;
            end
            default: rdata = cnt_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctrl     <= '0;
            reload   <= '0;
            flag     <= 1'b0;
            wrap_cnt <= '0;
            rc_valid <= 1'b0;
        end else begin
            rc_valid <= !load_o;
            if (ctrl_wr)   ctrl   <= wdata[3:0];
            if (reload_wr) reload <= wdata;

            if (wrap)                          flag <= 1'b1;
            else if (status_wr && wdata[0])    flag <= 1'b0;

            // Increment wins over a coincident clear.
            if (wrap) begin
                if (status_wr && wdata[1])     wrap_cnt <= WC_W'(1);
                else if (wrap_cnt != '1)       wrap_cnt <= wrap_cnt + WC_W'(1);
            end else if (status_wr && wdata[1]) begin
                wrap_cnt <= '0;
            end

            if (ctrl_wr && wdata[4]) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  if (ctrl_wr ? wdata[0] : ctrl[0]) state <= RUN;
                    RUN: begin
                        if (ctrl_wr && !wdata[0])    state <= PAUSE;
                        else if (wrap && !ctrl[2])   state <= DONE;
                    end
                    PAUSE: if (ctrl_wr && wdata[0]) state <= RUN;
                    DONE:  state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl; includes a behavioural model of the
// downstream up/down counter (registered Rc, Rc held during Load).
module tb_counter_timer_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         we = 1'b0;
    logic [1:0]   addr = 2'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata, cnt_in, pdata_o;
    logic         rc_in, load_o, s_o, irq_o;

    int errors = 0;
    int checks = 0;

    counter_timer_ctrl #(.W(W), .WC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .cnt_in(cnt_in), .rc_in(rc_in), .load_o(load_o),
        .s_o(s_o), .pdata_o(pdata_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Downstream counter: no enable, no reset.
    logic [W-1:0] cnt = '0;
    logic         rc  = 1'b0;
    always @(posedge clk) begin
        if (load_o) begin
            cnt <= pdata_o;
        end else if (s_o) begin
            cnt <= cnt + 1;
            rc  <= (cnt == '1);
        end else begin
            cnt <= cnt - 1;
            rc  <= (cnt == '0);
        end
    end
    assign cnt_in = cnt;
    assign rc_in  = rc;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [W-1:0] d;
        #2 rst_n = 1'b0;
        step(2);
        checks++; if ({load_o, s_o, irq_o} !== 3'b100) begin errors++;
            $display("FAIL reset_ctl_out: load/s/irq=%b expected 100", {load_o, s_o, irq_o}); end
        checks++; if (pdata_o !== '0) begin errors++;
            $display("FAIL reset_pdata: got %h expected 0", pdata_o); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++; if (d !== '0) begin errors++;
                $display("FAIL reset_reg%0d: got %h expected 0", a, d); end
        end
        rst_n = 1'b1;
        wr(2'd1, 32'h0000_1234);
        step(1);
        checks++; if (cnt_in !== 32'h0000_1234) begin errors++;
            $display("FAIL idle_reload_track: cnt %h expected 00001234", cnt_in); end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd1, d);
        checks++; if (d !== 32'h0000_1234) begin errors++;
            $display("FAIL count_write_ignored: reload %h expected 00001234", d); end
        rd(2'd0, d);
        checks++; if (d !== '0) begin errors++;
            $display("FAIL count_write_ctrl: ctrl %h expected 0", d); end
    endtask

    task automatic test_auto_down;
        logic [W-1:0] d, e;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h5);
        for (int i = 0; i < 21; i++) begin
            e = (i % 7 == 6) ? '1 : W'(5 - (i % 7));
            checks++; if (cnt_in !== e) begin errors++;
                $display("FAIL auto_down_cnt[%0d]: got %h expected %h", i, cnt_in, e); end
            if (i % 7 == 6) begin
                checks++; if ({load_o, pdata_o} !== {1'b1, 32'd5}) begin errors++;
                    $display("FAIL auto_reload_drive[%0d]: load %b pdata %h expected 1/5", i, load_o, pdata_o); end
            end
            step(1);
        end
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0301) begin errors++;
            $display("FAIL auto_down_status: got %h expected 00000301", d); end
        checks++; if (irq_o !== 1'b0) begin errors++;
            $display("FAIL irq_masked: got %b expected 0", irq_o); end
    endtask

    task automatic test_stale_rc;
        logic [W-1:0] d;
        bit found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (cnt_in == '1) found = 1'b1;
            else step(1);
        end
        checks++; if (!found) begin errors++;
            $display("FAIL stale_find_wrap: no wrap cycle within 10 cycles"); end
        wr(2'd0, 32'h4);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({load_o, cnt_in} !== {1'b1, 32'd5}) begin errors++;
                $display("FAIL pause_hold[%0d]: load %b cnt %h expected 1/5", i, load_o, cnt_in); end
            if (i < 2) step(1);
        end
        checks++; if (rc_in !== 1'b1) begin errors++;
            $display("FAIL pause_rc_stale: rc %b expected 1", rc_in); end
        wr(2'd0, 32'h5);
        checks++; if ({load_o, cnt_in} !== {1'b0, 32'd5}) begin errors++;
            $display("FAIL resume_first: load %b cnt %h expected 0/5", load_o, cnt_in); end
        step(1);
        checks++; if (cnt_in !== 32'd4) begin errors++;
            $display("FAIL resume_count: cnt %h expected 4", cnt_in); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0401) begin errors++;
            $display("FAIL stale_status: got %h expected 00000401", d); end
        wr(2'd0, 32'h10);
        wr(2'd2, 32'h3);
        rd(2'd2, d);
        checks++; if (d !== '0) begin errors++;
            $display("FAIL status_clear: got %h expected 0", d); end
    endtask

    task automatic test_one_shot;
        logic [W-1:0] d;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        step(4);
        checks++; if ({load_o, cnt_in, pdata_o} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin errors++;
            $display("FAIL oneshot_wrap: load %b cnt %h pdata %h expected 1/FFFFFFFF/FFFFFFFF", load_o, cnt_in, pdata_o); end
        step(1);
        checks++; if (irq_o !== 1'b1) begin errors++;
            $display("FAIL oneshot_irq: got %b expected 1", irq_o); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0101) begin errors++;
            $display("FAIL oneshot_status: got %h expected 00000101", d); end
        step(3);
        wr(2'd0, 32'h9);
        step(2);
        checks++; if ({load_o, cnt_in} !== {1'b1, 32'hFFFF_FFFF}) begin errors++;
            $display("FAIL done_hold: load %b cnt %h expected 1/FFFFFFFF", load_o, cnt_in); end
        wr(2'd2, 32'h1);
        checks++; if (irq_o !== 1'b0) begin errors++;
            $display("FAIL irq_clear: got %b expected 0", irq_o); end
        wr(2'd0, 32'h19);
        checks++; if ({load_o, pdata_o} !== {1'b1, 32'd3}) begin errors++;
            $display("FAIL restart_idle: load %b pdata %h expected 1/3", load_o, pdata_o); end
        step(1);
        checks++; if ({load_o, cnt_in} !== {1'b0, 32'd3}) begin errors++;
            $display("FAIL restart_run: load %b cnt %h expected 0/3", load_o, cnt_in); end
        rd(2'd0, d);
        checks++; if (d !== 32'h9) begin errors++;
            $display("FAIL restart_reads0: ctrl %h expected 9", d); end
        wr(2'd0, 32'h10);
        wr(2'd2, 32'h3);
    endtask

    task automatic test_up_mode;
        logic [W-1:0] d, e;
        wr(2'd1, 32'hFFFF_FFFD);
        wr(2'd0, 32'h7);
        checks++; if (s_o !== 1'b1) begin errors++;
            $display("FAIL up_dir: s %b expected 1", s_o); end
        for (int i = 0; i < 12; i++) begin
            e = 32'hFFFF_FFFD + W'(i % 4);
            checks++; if (cnt_in !== e) begin errors++;
                $display("FAIL up_cnt[%0d]: got %h expected %h", i, cnt_in, e); end
            step(1);
        end
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0301) begin errors++;
            $display("FAIL up_status: got %h expected 00000301", d); end
        wr(2'd0, 32'h10);
        wr(2'd2, 32'h3);
    endtask

    task automatic test_saturation;
        logic [W-1:0] d;
        bit found = 1'b0;
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h5);
        step(530);
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_FF01) begin errors++;
            $display("FAIL wrap_saturate: got %h expected 0000FF01", d); end
        for (int i = 0; i < 4 && !found; i++) begin
            if (cnt_in == '1) found = 1'b1;
            else step(1);
        end
        checks++; if (!found) begin errors++;
            $display("FAIL sat_find_wrap: no wrap cycle within 4 cycles"); end
        wr(2'd2, 32'h2);
        rd(2'd2, d);
        checks++; if (d !== 32'h0000_0101) begin errors++;
            $display("FAIL clear_race: got %h expected 00000101", d); end
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] d;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({load_o, pdata_o, irq_o} !== {1'b1, 32'd0, 1'b0}) begin errors++;
            $display("FAIL async_reset: load %b pdata %h irq %b expected 1/0/0", load_o, pdata_o, irq_o); end
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), d);
            checks++; if (d !== '0) begin errors++;
                $display("FAIL midrun_reg%0d: got %h expected 0", a, d); end
        end
        @(negedge clk);
        rd(2'd3, d);
        checks++; if (d !== '0) begin errors++;
            $display("FAIL midrun_count: got %h expected 0", d); end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_auto_down();
        test_stale_rc();
        test_one_shot();
        test_up_mode();
        test_saturation();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
